// File: rtl/led_meter_pkg.sv
// ---------------------------------------------------------------------------
// led_meter_pkg
// Shared types for the LED level meter: display mode encoding and the
// segment-count type used between the scaler and the display logic.
// ---------------------------------------------------------------------------
package led_meter_pkg;

    typedef enum logic [1:0] {
        MODE_VOL = 2'b00,  // volume pot as a bar
        MODE_BAR = 2'b01,  // audio envelope as a bar
        MODE_DOT = 2'b10,  // audio envelope as a single dot
        MODE_OFF = 2'b11   // all LEDs dark
    } meter_mode_t;

    // Largest supported LED count; seg_t must be able to hold 0..MAX_LED.
    localparam int MAX_LED = 16;

    function automatic int seg_width(input int num_led);
        return $clog2(num_led + 1);
    endfunction

    localparam int SEG_W = seg_width(MAX_LED);

    typedef logic [SEG_W-1:0] seg_t;

endpackage

// File: rtl/led_level_meter_seg_quant.sv
// ---------------------------------------------------------------------------
// seg_quant
// Combinational scaler from an unsigned level to a lit-segment count:
//   seg = (level < FLOOR) ? 0 : min(NUM_LED, (level*NUM_LED + ROUND) >> SHIFT)
// Ports:
//   level  in  IN_W   unsigned level (volume or envelope)
//   seg    out seg_t  number of segments to light, 0..NUM_LED
// ---------------------------------------------------------------------------
module seg_quant
    import led_meter_pkg::*;
#(
    parameter int IN_W    = 16,
    parameter int NUM_LED = 8,
    parameter int SHIFT   = 14,
    parameter int FLOOR   = 0,
    parameter int ROUND   = 0
) (
    input  logic [IN_W-1:0] level,
    output seg_t            seg
);

    // One guard bit above level*NUM_LED so the rounding bias cannot wrap.
    localparam int PROD_W = IN_W + $clog2(NUM_LED) + 1;

    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] quot;
    logic              below;

    assign prod = PROD_W'(level) * PROD_W'(NUM_LED) + PROD_W'(ROUND);
    assign quot = prod >> SHIFT;

    generate
        if (FLOOR > 0) begin : g_floor
            assign below = (level < IN_W'(FLOOR));
        end else begin : g_no_floor
            assign below = 1'b0;
        end
    endgenerate

    always_comb begin
        // NOTE: every branch assigns seg; a missing else here would infer a latch.
        if (below) begin
            seg = '0;
        end else if (quot > PROD_W'(NUM_LED)) begin
            seg = SEG_W'(NUM_LED);
        end else begin
            seg = quot[SEG_W-1:0];
        end
    end

endmodule

// File: rtl/led_level_meter.sv
// ---------------------------------------------------------------------------
// led_level_meter
// Parametrised LED bar/dot level meter. Shows the volume pot value or the
// decaying audio envelope max(|lft|,|rht|) on NUM_LED active-high LEDs.
// Optional peak-hold marker when LED_PEAK_HOLD_EN is defined; without it
// no peak/hold registers exist and the LEDs show the plain bar/dot.
// Ports:
//   clk      in  1        system clock
//   rst_n    in  1        asynchronous active-low reset
//   smp_vld  in  1        one-cycle strobe, lft_smp/rht_smp valid
//   lft_smp  in  SMP_W    signed left sample
//   rht_smp  in  SMP_W    signed right sample
//   volume   in  LVL_W    unsigned volume pot value
//   mode     in  2        00 volume bar, 01 audio bar, 10 audio dot, 11 off
//   LED      out NUM_LED  registered LED drive
// Pipeline: inputs (sample/volume/mode) are registered once, the LED
// register follows, so any input change shows on LED two cycles later.
// ---------------------------------------------------------------------------
module led_level_meter
    import led_meter_pkg::*;
#(
    parameter int NUM_LED     = 8,
    parameter int LVL_W       = 13,
    parameter int SMP_W       = 16,
    parameter int VOL_FLOOR   = 64,
    parameter int DECAY_SHIFT = 10,
    parameter int HOLD_SMP    = 4800
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               smp_vld,
    input  logic [SMP_W-1:0]   lft_smp,
    input  logic [SMP_W-1:0]   rht_smp,
    input  logic [LVL_W-1:0]   volume,
    input  logic [1:0]         mode,
    output logic [NUM_LED-1:0] LED
);

    // Absolute value of a two's-complement sample; the most negative code
    // saturates to the largest positive code instead of wrapping.
    function automatic logic [SMP_W-1:0] sat_abs(input logic [SMP_W-1:0] s);
        logic [SMP_W-1:0] a;
        a = s[SMP_W-1] ? (-s) : s;
        return a[SMP_W-1] ? {1'b0, {(SMP_W-1){1'b1}}} : a;
    endfunction

    function automatic logic [NUM_LED-1:0] bar_of(input seg_t s);
        return ~({NUM_LED{1'b1}} << s);
    endfunction

    function automatic logic [NUM_LED-1:0] dot_of(input seg_t s);
        return (s == '0) ? '0 : (NUM_LED'(1) << (s - seg_t'(1)));
    endfunction

    logic [SMP_W-1:0]   env;
    logic [SMP_W-1:0]   env_nxt;
    logic [SMP_W-1:0]   mag;
    logic [SMP_W-1:0]   decay;
    logic [LVL_W-1:0]   vol_q;
    meter_mode_t        mode_q;
    seg_t               seg_vol;
    seg_t               seg_aud;
    logic [NUM_LED-1:0] peak_bits;
    logic [NUM_LED-1:0] led_nxt;

    // Envelope: instant attack, exponential release (env/2^DECAY_SHIFT per
    // sample) with a minimum step of 1 so it always reaches zero.
    always_comb begin
        mag   = (sat_abs(lft_smp) > sat_abs(rht_smp)) ? sat_abs(lft_smp) : sat_abs(rht_smp);
        decay = env >> DECAY_SHIFT;
        if (decay == '0) begin
            decay = SMP_W'(1);
        end
        if (mag > env) begin
            env_nxt = mag;
        end else if (env == '0) begin
            env_nxt = '0;
        end else begin
            env_nxt = env - decay;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            env    <= '0;
            vol_q  <= '0;
            mode_q <= MODE_VOL;
            LED    <= '0;
        end else begin
            if (smp_vld) begin
                env <= env_nxt;
            end
            vol_q  <= volume;
            mode_q <= meter_mode_t'(mode);
            LED    <= led_nxt;
        end
    end

    seg_quant #(
        .IN_W    (LVL_W),
        .NUM_LED (NUM_LED),
        .SHIFT   (LVL_W),
        .FLOOR   (VOL_FLOOR),
        .ROUND   (2**LVL_W - 1)
    ) u_vol_quant (
        .level (vol_q),
        .seg   (seg_vol)
    );

    // Half of full-scale lights every LED; the clamp in seg_quant keeps
    // louder envelopes at NUM_LED (6 dB of headroom at the top of the bar).
    seg_quant #(
        .IN_W    (SMP_W),
        .NUM_LED (NUM_LED),
        .SHIFT   (SMP_W - 2),
        .FLOOR   (0),
        .ROUND   (0)
    ) u_aud_quant (
        .level (env),
        .seg   (seg_aud)
    );

`ifdef LED_PEAK_HOLD_EN
    localparam int HOLD_W = (HOLD_SMP > 1) ? $clog2(HOLD_SMP) : 1;

    seg_t              peak;
    logic [HOLD_W-1:0] hold_cnt;
    logic              vld_q;

    // The peak follows the audio segment of the freshly updated envelope,
    // so it runs on the sample strobe delayed by one cycle. A new maximum
    // restarts the hold timer even on the cycle the timer would expire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q    <= 1'b0;
            peak     <= '0;
            hold_cnt <= '0;
        end else begin
            vld_q <= smp_vld;
            if (vld_q) begin
                if (seg_aud > peak) begin
                    peak     <= seg_aud;
                    hold_cnt <= HOLD_W'(HOLD_SMP - 1);
                end else if (hold_cnt == '0) begin
                    if (peak != '0) begin
                        peak <= peak - seg_t'(1);
                    end
                    hold_cnt <= HOLD_W'(HOLD_SMP - 1);
                end else begin
                    hold_cnt <= hold_cnt - HOLD_W'(1);
                end
            end
        end
    end

    assign peak_bits = dot_of(peak);
`else
    assign peak_bits = '0;
`endif

    always_comb begin
        led_nxt = '0;
        case (mode_q)
            MODE_VOL: led_nxt = bar_of(seg_vol);
            MODE_BAR: led_nxt = bar_of(seg_aud) | peak_bits;
            MODE_DOT: led_nxt = dot_of(seg_aud) | peak_bits;
            default:  led_nxt = '0;
        endcase
    end

endmodule

// File: tb/tb_led_level_meter.sv
// ---------------------------------------------------------------------------
// tb_led_level_meter
// Self-checking bench for led_level_meter: an 8-LED and a 5-LED instance
// share the same stimulus; a behavioural model (integer arithmetic on the
// envelope/segment rules) predicts both LED buses every cycle. Inputs are
// driven on the falling edge and LEDs are checked on the falling edge.
// ---------------------------------------------------------------------------
module tb_led_level_meter;

    localparam int HOLD = 4800;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        smp_vld;
    logic [15:0] lft_smp;
    logic [15:0] rht_smp;
    logic [12:0] volume;
    logic [1:0]  mode;
    logic [7:0]  led8;
    logic [4:0]  led5;

    int n_pass = 0;
    int n_checks = 0;

    always #10 clk = ~clk;

    led_level_meter u_dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .smp_vld (smp_vld),
        .lft_smp (lft_smp),
        .rht_smp (rht_smp),
        .volume  (volume),
        .mode    (mode),
        .LED     (led8)
    );

    led_level_meter #(.NUM_LED(5)) u_dut5 (
        .clk     (clk),
        .rst_n   (rst_n),
        .smp_vld (smp_vld),
        .lft_smp (lft_smp),
        .rht_smp (rht_smp),
        .volume  (volume),
        .mode    (mode),
        .LED     (led5)
    );

    // ---------------- reference model ----------------
    function automatic int abs_sat(input logic [15:0] s);
        int v;
        v = $signed(s);
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return v;
    endfunction

    function automatic int env_after(input int env, input logic [15:0] l, input logic [15:0] r);
        int m;
        int d;
        m = (abs_sat(l) > abs_sat(r)) ? abs_sat(l) : abs_sat(r);
        if (m > env) return m;
        if (env == 0) return 0;
        d = env / 1024;
        if (d < 1) d = 1;
        return env - d;
    endfunction

    // Half of full scale (16384) lights all n LEDs.
    function automatic int aud_seg(input int env, input int n);
        int s;
        s = (env * n) / 16384;
        return (s > n) ? n : s;
    endfunction

    function automatic int vol_seg(input int vol, input int n);
        int s;
        if (vol < 64) return 0;
        s = (vol * n + 8191) / 8192;
        return (s > n) ? n : s;
    endfunction

    function automatic int show(input int n, input int md, input int vol, input int env, input int pk);
        int s;
        int led;
        s = (md == 0) ? vol_seg(vol, n) : aud_seg(env, n);
        case (md)
            0, 1:    led = (1 << s) - 1;
            2:       led = (s == 0) ? 0 : (1 << (s - 1));
            default: led = 0;
        endcase
        if ((md == 1 || md == 2) && pk != 0) led = led | (1 << (pk - 1));
        return led;
    endfunction

    int         m_env;
    int         m_mode;
    int         m_vol;
    logic       m_vldq;
    int         m_peak [2];
    int         m_hold [2];
    int         m_seg;
    logic [7:0] exp8;
    logic [4:0] exp5;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_env  = 0;
            m_mode = 0;
            m_vol  = 0;
            m_vldq = 1'b0;
            m_peak = '{0, 0};
            m_hold = '{0, 0};
            exp8   = '0;
            exp5   = '0;
        end else begin
            exp8 = 8'(show(8, m_mode, m_vol, m_env, m_peak[0]));
            exp5 = 5'(show(5, m_mode, m_vol, m_env, m_peak[1]));
`ifdef LED_PEAK_HOLD_EN
            if (m_vldq) begin
                for (int k = 0; k < 2; k++) begin
                    m_seg = aud_seg(m_env, (k == 0) ? 8 : 5);
                    if (m_seg > m_peak[k]) begin
                        m_peak[k] = m_seg;
                        m_hold[k] = HOLD - 1;
                    end else if (m_hold[k] == 0) begin
                        if (m_peak[k] > 0) m_peak[k] = m_peak[k] - 1;
                        m_hold[k] = HOLD - 1;
                    end else begin
                        m_hold[k] = m_hold[k] - 1;
                    end
                end
            end
`endif
            m_vldq = smp_vld;
            m_mode = int'(mode);
            m_vol  = int'(volume);
            if (smp_vld) m_env = env_after(m_env, lft_smp, rht_smp);
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_checks++;
        assert (got === want) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, want);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_n8"}, 16'(led8), 16'(exp8));
        check({tag, "_n5"}, 16'(led5), 16'(exp5));
    endtask

    task automatic drive(input logic v, input logic [15:0] l, input logic [15:0] r);
        smp_vld = v;
        lft_smp = l;
        rht_smp = r;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    logic [7:0]  prev8;
    logic [12:0] vol_tab  [5] = '{13'd63, 13'd64, 13'd1024, 13'd1025, 13'd8191};
    logic [7:0]  exp8_tab [5] = '{8'h00, 8'h01, 8'h01, 8'h03, 8'hFF};
    logic [4:0]  exp5_tab [5] = '{5'h00, 5'h01, 5'h01, 5'h01, 5'h1F};

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 16'h0000, 16'h0000);
        volume = '0;
        mode   = 2'b00;
        wait_cyc(3);
        check("reset_led8", 16'(led8), 16'h0000);
        check("reset_led5", 16'(led5), 16'h0000);
        rst_n = 1'b1;

        // Volume bar thresholds.
        for (int i = 0; i < 5; i++) begin
            volume = vol_tab[i];
            wait_cyc(2);
            check($sformatf("vol_%0d_n8", vol_tab[i]), 16'(led8), 16'(exp8_tab[i]));
            check($sformatf("vol_%0d_n5", vol_tab[i]), 16'(led5), 16'(exp5_tab[i]));
            check_model("vol_model");
        end

        // Audio bar: most negative sample saturates to full scale.
        mode = 2'b01;
        drive(1'b1, 16'h8000, 16'h0000);
        wait_cyc(1);
        drive(1'b1, 16'h0000, 16'h0000);
        wait_cyc(1);
        check("aud_fullscale", 16'(led8), 16'h00FF);
        check_model("aud_fs_model");
        prev8 = led8;
        for (int i = 0; i < 5000; i++) begin
            wait_cyc(1);
`ifndef LED_PEAK_HOLD_EN
            check("decay_monotonic", 16'(led8 & ~prev8), 16'h0000);
`endif
            if (i % 16 == 0) check_model("decay_model");
            prev8 = led8;
        end
`ifndef LED_PEAK_HOLD_EN
        check("decay_to_zero", 16'(led8), 16'h0000);
`endif

        // Asynchronous reset mid-run with a loud envelope.
        drive(1'b1, 16'h7000, 16'h0000);
        wait_cyc(1);
        drive(1'b0, 16'h0000, 16'h0000);
        wait_cyc(1);
        check("pre_reset_full", 16'(led8), 16'h00FF);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_led8", 16'(led8), 16'h0000);
        check("async_reset_led5", 16'(led5), 16'h0000);
        wait_cyc(2);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_cyc(1);
            check("post_reset_zero", 16'(led8), 16'h0000);
        end

        // Dot mode: max(|0x3000|, |-0x1000|) -> 6 of 8 segments.
        mode = 2'b10;
        drive(1'b1, 16'hF000, 16'h3000);
        wait_cyc(1);
        drive(1'b0, 16'h0000, 16'h0000);
        wait_cyc(1);
        check("dot_seg6", 16'(led8), 16'h0020);
        check_model("dot_model");

        // Randomized traffic against the model, all modes.
        for (int i = 0; i < 600; i++) begin
            check_model("random");
            smp_vld = 1'($urandom_range(0, 1));
            lft_smp = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
            rht_smp = ($urandom_range(0, 7) == 0) ? 16'h7FFF : 16'($urandom >> $urandom_range(0, 15));
            volume  = ($urandom_range(0, 3) == 0) ? 13'($urandom_range(60, 70)) : 13'($urandom);
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
            wait_cyc(1);
        end
        wait_cyc(1);
        check_model("random_tail");

`ifdef LED_PEAK_HOLD_EN
        // Peak hold: full-scale pulse then silence at one sample per cycle.
        rst_n = 1'b0;
        wait_cyc(1);
        rst_n = 1'b1;
        mode = 2'b01;
        drive(1'b1, 16'h7FFF, 16'h0000);
        wait_cyc(1);
        drive(1'b1, 16'h0000, 16'h0000);
        for (int i = 0; i < 10200; i++) begin
            wait_cyc(1);
            if (i % 32 == 0) check_model("peak_model");
            if (i == 4000) check("peak_held_bit7", 16'(led8[7]), 16'h0001);
            if (i == 5500) check("peak_drop_one", 16'(led8), 16'h0040);
            if (i == 10000) check("peak_drop_two", 16'(led8), 16'h0020);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
